// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the alu_issue front end.
// Holds XLEN, ALU funct encodings, the S1 payload struct and a source-match helper.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SLL  = 4'd1,
    SLT  = 4'd2,
    SLTU = 4'd3,
    XOR  = 4'd4,
    SRL  = 4'd5,
    OR   = 4'd6,
    AND  = 4'd7,
    SUB  = 4'd8,
    SRA  = 4'd13
  } alu_funct_e;

  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            a_pc;
    logic            b_imm;
    logic [3:0]      funct;
  } s1_t;

  // A used, non-x0 source produced by a valid in-flight rd.
  function automatic logic rd_match(
    input logic       use_src,
    input logic [4:0] src,
    input logic       cand_valid,
    input logic [4:0] cand_rd
  );
    return use_src && cand_valid &&
           (src != 5'd0) && (cand_rd == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: per-operand bypass compare and select.
// Ports: source idx/use/reg-select, reg and alt values, candidate rd/valid/data -> src_val, opnd.
module fwd_mux
  import alu_pkg::*;
(
  input  logic [4:0]      src,
  input  logic            use_src,
  input  logic            sel_reg,
  input  logic [XLEN-1:0] reg_val,
  input  logic [XLEN-1:0] alt_val,
  input  logic            cand_valid,
  input  logic [4:0]      cand_rd,
  input  logic [XLEN-1:0] cand_data,
  output logic [XLEN-1:0] src_val,
  output logic [XLEN-1:0] opnd
);

  logic hit;

  // PC/immediate operands never take a bypass.
  assign hit = sel_reg &&
               rd_match(use_src, src, cand_valid, cand_rd);

  always_comb begin
    src_val = hit ? cand_data : reg_val;
    opnd    = sel_reg ? src_val : alt_val;
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage operand issue (S1) and ALU result capture (S2).
// Ports: decode op in (in_valid/in_ready), alu_a/alu_b/alu_funct out, alu_o in,
// writeback out (wb_valid/wb_ready, wb_rd, wb_data). Sync active-high rst.
// ALU_ISSUE_FWD_EN: entry + ALU bypass; undefined -> decode interlock.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_use_rs1,
  input  logic            in_use_rs2,
  input  logic            in_a_pc,
  input  logic            in_b_imm,
  input  logic [3:0]      in_funct,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_funct,
  input  logic [XLEN-1:0] alu_o,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  import alu_pkg::s1_t;
  import alu_pkg::rd_match;

  s1_t             s1_q, s1_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  logic [4:0]      s2_rd_q, s2_rd_d;
  logic [XLEN-1:0] s2_data_q, s2_data_d;

  logic            s1_adv;
  logic            wb_fire;
  logic            accept;
  logic            hazard;
  logic [XLEN-1:0] ent_a, ent_b;
  logic [XLEN-1:0] ent_rs1, ent_rs2;

  assign s1_adv   = s1_valid_q &&
                    (!s2_valid_q || wb_ready);
  assign wb_fire  = s2_valid_q && wb_ready;
  assign in_ready = (!s1_valid_q || s1_adv) && !hazard;
  assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_FWD_EN
  logic [XLEN-1:0] alu_rs1_unused, alu_rs2_unused;

  assign hazard = 1'b0;

  // Entry bypass: result retiring on the accept edge.
  fwd_mux u_ent_a (
    .src        (in_rs1),
    .use_src    (in_use_rs1),
    .sel_reg    (!in_a_pc),
    .reg_val    (in_rs1_val),
    .alt_val    (in_pc),
    .cand_valid (wb_fire),
    .cand_rd    (s2_rd_q),
    .cand_data  (s2_data_q),
    .src_val    (ent_rs1),
    .opnd       (ent_a)
  );

  fwd_mux u_ent_b (
    .src        (in_rs2),
    .use_src    (in_use_rs2),
    .sel_reg    (!in_b_imm),
    .reg_val    (in_rs2_val),
    .alt_val    (in_imm),
    .cand_valid (wb_fire),
    .cand_rd    (s2_rd_q),
    .cand_data  (s2_data_q),
    .src_val    (ent_rs2),
    .opnd       (ent_b)
  );

  // ALU bypass: producer sitting in S2 while consumer is in S1.
  fwd_mux u_alu_a (
    .src        (s1_q.rs1),
    .use_src    (s1_q.use_rs1),
    .sel_reg    (!s1_q.a_pc),
    .reg_val    (s1_q.rs1_val),
    .alt_val    (s1_q.op_a),
    .cand_valid (s2_valid_q),
    .cand_rd    (s2_rd_q),
    .cand_data  (s2_data_q),
    .src_val    (alu_rs1_unused),
    .opnd       (alu_a)
  );

  fwd_mux u_alu_b (
    .src        (s1_q.rs2),
    .use_src    (s1_q.use_rs2),
    .sel_reg    (!s1_q.b_imm),
    .reg_val    (s1_q.rs2_val),
    .alt_val    (s1_q.op_b),
    .cand_valid (s2_valid_q),
    .cand_rd    (s2_rd_q),
    .cand_data  (s2_data_q),
    .src_val    (alu_rs2_unused),
    .opnd       (alu_b)
  );
`else
  logic [11:0] s1_src_unused;

  assign ent_rs1 = in_rs1_val;
  assign ent_rs2 = in_rs2_val;
  assign ent_a   = in_a_pc  ? in_pc  : in_rs1_val;
  assign ent_b   = in_b_imm ? in_imm : in_rs2_val;
  assign alu_a   = s1_q.a_pc  ? s1_q.op_a : s1_q.rs1_val;
  assign alu_b   = s1_q.b_imm ? s1_q.op_b : s1_q.rs2_val;

  // Hold decode while any in-flight writer (even one
  // retiring now) targets a used source: the register
  // file value is not yet current.
  assign hazard =
    rd_match(in_use_rs1, in_rs1, s1_valid_q, s1_q.rd) ||
    rd_match(in_use_rs1, in_rs1, s2_valid_q, s2_rd_q) ||
    rd_match(in_use_rs2, in_rs2, s1_valid_q, s1_q.rd) ||
    rd_match(in_use_rs2, in_rs2, s2_valid_q, s2_rd_q);

  assign s1_src_unused = {s1_q.rs1, s1_q.rs2,
                          s1_q.use_rs1, s1_q.use_rs2};
`endif

  assign alu_funct = s1_q.funct;
  assign wb_valid  = s2_valid_q;
  assign wb_rd     = s2_rd_q;
  assign wb_data   = s2_data_q;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_d.op_a    = ent_a;
      s1_d.op_b    = ent_b;
      s1_d.rs1_val = ent_rs1;
      s1_d.rs2_val = ent_rs2;
      s1_d.rs1     = in_rs1;
      s1_d.rs2     = in_rs2;
      s1_d.rd      = in_rd;
      s1_d.use_rs1 = in_use_rs1;
      s1_d.use_rs2 = in_use_rs2;
      s1_d.a_pc    = in_a_pc;
      s1_d.b_imm   = in_b_imm;
      s1_d.funct   = in_funct;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_rd_d    = s2_rd_q;
    s2_data_d  = s2_data_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_rd_d    = s1_q.rd;
      s2_data_d  = alu_o;
    end else if (wb_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_rd_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_rd_q    <= s2_rd_d;
      s2_data_q  <= s2_data_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: table vectors, directed corner sequences and random
// traffic for alu_issue, checked against an in-order register-file model.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_a_pc, in_b_imm;
  logic [3:0]  in_funct;
  logic [31:0] alu_a, alu_b, alu_o;
  logic [3:0]  alu_funct;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val),
    .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_a_pc(in_a_pc), .in_b_imm(in_b_imm),
    .in_funct(in_funct),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct),
    .alu_o(alu_o),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  function automatic logic [31:0] alu_f(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] f);
    case (f)
      ADD:     return a + b;
      SUB:     return a - b;
      SLL:     return a << b[4:0];
      SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU:    return (a < b) ? 32'd1 : 32'd0;
      XOR:     return a ^ b;
      SRL:     return a >> b[4:0];
      SRA:     return $unsigned($signed(a) >>> b[4:0]);
      OR:      return a | b;
      AND:     return a & b;
      default: return a + b;
    endcase
  endfunction

  always_comb alu_o = alu_f(alu_a, alu_b, alu_funct);

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, a_pc, b_imm;
    logic [3:0]  funct;
  } op_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a, b, pc, imm;
    logic        a_pc, b_imm;
    logic [31:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] commit_regs [32];
  logic [31:0] spec_regs [32];
  res_t exp_q [$];
  res_t log_q [$];
  int   log_cyc [$];

  logic        last_fire = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_rd;
  res_t        mon_e;
  logic [31:0] mon_a, mon_b, mon_r;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: mid-cycle, sees the handshakes of the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) spec_regs[i] = commit_regs[i];
      prev_stall = 1'b0;
      last_fire = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, wb_valid}, 32'd1);
        chk("stall_data", wb_data, prev_data);
        chk("stall_rd", {27'd0, wb_rd}, {27'd0, prev_rd});
      end
      prev_stall = wb_valid && !wb_ready;
      prev_data = wb_data;
      prev_rd = wb_rd;
      if (wb_valid && wb_ready) begin
        chk("wb_has_expect", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
          chk("wb_data", wb_data, mon_e.data);
          if (mon_e.rd != 5'd0) commit_regs[mon_e.rd] = mon_e.data;
        end
        log_q.push_back('{wb_rd, wb_data});
        log_cyc.push_back(cyc);
      end
      last_fire = in_valid && in_ready;
      if (last_fire) begin
        mon_a = in_a_pc ? in_pc : spec_regs[in_rs1];
        mon_b = in_b_imm ? in_imm : spec_regs[in_rs2];
        mon_r = alu_f(mon_a, mon_b, in_funct);
        exp_q.push_back('{in_rd, mon_r});
        if (in_rd != 5'd0) spec_regs[in_rd] = mon_r;
      end
    end
  end

  function automatic op_t mk_op(
    input logic [3:0] f, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic a_pc, input logic b_imm,
    input logic [31:0] pc, input logic [31:0] imm);
    op_t o;
    o.funct = f; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
    o.a_pc = a_pc; o.b_imm = b_imm; o.pc = pc; o.imm = imm;
    o.use1 = !a_pc; o.use2 = !b_imm;
    return o;
  endfunction

  task automatic drive(input op_t o);
    in_pc = o.pc; in_imm = o.imm;
    in_rs1 = o.rs1; in_rs2 = o.rs2; in_rd = o.rd;
    in_use_rs1 = o.use1; in_use_rs2 = o.use2;
    in_a_pc = o.a_pc; in_b_imm = o.b_imm;
    in_funct = o.funct;
    in_rs1_val = commit_regs[o.rs1];
    in_rs2_val = commit_regs[o.rs2];
  endtask

  task automatic send(input op_t o);
    int n = 0;
    logic ok = 1'b0;
    drive(o);
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) drive(o);
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_results(input int target);
    int n = 0;
    while (log_q.size() < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("results_arrived", {31'd0, log_q.size() >= target}, 32'd1);
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    commit_regs[i] = v;
    spec_regs[i] = v;
  endtask

  function automatic op_t rand_op();
    logic [3:0] fl [10];
    op_t o;
    fl = '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND};
    o.funct = fl[$urandom_range(0, 9)];
    o.rd  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                        : 5'($urandom_range(0, 3));
    o.rs1 = 5'($urandom_range(0, 3));
    o.rs2 = 5'($urandom_range(0, 3));
    o.a_pc  = ($urandom_range(0, 4) == 0);
    o.b_imm = ($urandom_range(0, 2) == 0);
    o.use1 = o.a_pc ? 1'($urandom_range(0, 1)) : 1'b1;
    o.use2 = o.b_imm ? 1'($urandom_range(0, 1)) : 1'b1;
    o.pc  = $urandom;
    o.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    return o;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    op_t  op;
    int   base;
    int   n;
    logic have;

    for (int i = 0; i < 32; i++) set_reg(i, 32'd0);

    // Reset with a valid op presented that must not be taken.
    rst = 1'b1;
    wb_ready = 1'b0;
    drive(mk_op(ADD, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 32'h1234, 32'h55));
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_funct", {28'd0, alu_funct}, 32'd0);
    @(negedge clk);
    chk("rst_no_accept", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    #1;
    wb_ready = 1'b1;

    // Single-op vectors through every function and the PC/imm path.
    tbl[0]  = '{ADD,  32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'd12};
    tbl[1]  = '{SUB,  32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFE};
    tbl[2]  = '{SLL,  32'd1, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'd16};
    tbl[3]  = '{SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32'd1};
    tbl[4]  = '{SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0};
    tbl[5]  = '{XOR,  32'hF0F0, 32'hFF00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0FF0};
    tbl[6]  = '{SRL,  32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0800_0000};
    tbl[7]  = '{SRA,  32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'hF800_0000};
    tbl[8]  = '{OR,   32'hF0, 32'h0F, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFF};
    tbl[9]  = '{AND,  32'hF0, 32'h3C, 32'd0, 32'd0, 1'b0, 1'b0, 32'h30};
    tbl[10] = '{ADD,  32'hDEAD_0000, 32'd3, 32'h100, 32'h10, 1'b1, 1'b1, 32'h110};

    for (int i = 0; i < 11; i++) begin
      set_reg(20, tbl[i].a);
      set_reg(21, tbl[i].b);
      base = log_q.size();
      send(mk_op(tbl[i].f, 5'd22, 5'd20, 5'd21, tbl[i].a_pc,
                 tbl[i].b_imm, tbl[i].pc, tbl[i].imm));
      wait_results(base + 1);
      chk($sformatf("vec%0d_data", i), log_q[base].data, tbl[i].exp);
    end

    // Back-to-back dependency with a stale register value.
    set_reg(10, 32'd5);
    set_reg(11, 32'd7);
    base = log_q.size();
    send(mk_op(ADD, 5'd1, 5'd10, 5'd11, 1'b0, 1'b0, 32'd0, 32'd0));
    send(mk_op(SUB, 5'd2, 5'd1, 5'd0, 1'b0, 1'b1, 32'd0, 32'd2));
    wait_results(base + 2);
    chk("dep_x1_rd", {27'd0, log_q[base].rd}, 32'd1);
    chk("dep_x1_data", log_q[base].data, 32'd12);
    chk("dep_x2_rd", {27'd0, log_q[base+1].rd}, 32'd2);
    chk("dep_x2_data", log_q[base+1].data, 32'd10);
`ifdef ALU_ISSUE_FWD_EN
    chk("dep_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'd1);
`else
    chk("dep_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'd3);
`endif

    // x0 destination must not forward.
    set_reg(12, 32'd3);
    set_reg(13, 32'd4);
    base = log_q.size();
    send(mk_op(ADD, 5'd0, 5'd12, 5'd13, 1'b0, 1'b0, 32'd0, 32'd0));
    send(mk_op(ADD, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 32'd0, 32'd1));
    wait_results(base + 2);
    chk("x0_rd", {27'd0, log_q[base+1].rd}, 32'd3);
    chk("x0_data", log_q[base+1].data, 32'd1);

    // Writeback stall with three ops queued.
    wb_ready = 1'b0;
    base = log_q.size();
    send(mk_op(ADD, 5'd5, 5'd10, 5'd0, 1'b0, 1'b1, 32'd0, 32'd1));
    send(mk_op(ADD, 5'd6, 5'd10, 5'd0, 1'b0, 1'b1, 32'd0, 32'd2));
    drive(mk_op(ADD, 5'd7, 5'd10, 5'd0, 1'b0, 1'b1, 32'd0, 32'd3));
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_wb_head", wb_data, 32'd6);
      @(posedge clk);
      #1;
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_results(base + 3);
    chk("drain0", log_q[base].data, 32'd6);
    chk("drain1", log_q[base+1].data, 32'd7);
    chk("drain2", log_q[base+2].data, 32'd8);
    chk("drain_gap1", 32'(log_cyc[base+1] - log_cyc[base]), 32'd1);
    chk("drain_gap2", 32'(log_cyc[base+2] - log_cyc[base+1]), 32'd1);

    // PC/immediate select right behind a writer of rs1/rs2.
    base = log_q.size();
    send(mk_op(ADD, 5'd1, 5'd10, 5'd11, 1'b0, 1'b0, 32'd0, 32'd0));
    op = mk_op(ADD, 5'd4, 5'd1, 5'd1, 1'b1, 1'b1, 32'h100, 32'h10);
    op.use1 = 1'b1;
    op.use2 = 1'b1;
    send(op);
    wait_results(base + 2);
    chk("pcimm_data", log_q[base+1].data, 32'h110);

    // Reset with both stages full.
    wb_ready = 1'b0;
    send(mk_op(ADD, 5'd5, 5'd10, 5'd0, 1'b0, 1'b1, 32'd0, 32'd9));
    send(mk_op(ADD, 5'd6, 5'd10, 5'd0, 1'b0, 1'b1, 32'd0, 32'd9));
    base = log_q.size();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    wb_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(log_q.size()), 32'(base));

    // Random traffic against the in-order model.
    have = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      wb_ready = ($urandom_range(0, 9) < 7);
      if (have && !last_fire) begin
        drive(op);
      end else if ($urandom_range(0, 3) != 0) begin
        op = rand_op();
        drive(op);
        in_valid = 1'b1;
        have = 1'b1;
      end else begin
        in_valid = 1'b0;
        have = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("final_empty", 32'(exp_q.size()), 32'd0);
    chk("final_wb_valid", {31'd0, wb_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage execute front end that sits directly upstream of the ALU and feeds it. It accepts decoded RV32 integer ops from decode over a valid/ready handshake, resolves operands (register/PC/immediate plus result forwarding), and drives the ALU's `a`, `b` and `funct` inputs from a registered stage. It then captures the ALU result into a writeback register with its own valid/ready handshake.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode presents an op.
- `in_ready` out 1: op accepted on the edge where `in_valid && in_ready`.
- `in_pc` in 32: PC of the op.
- `in_rs1_val`, `in_rs2_val` in 32: register file read values.
- `in_imm` in 32: sign-extended immediate.
- `in_rs1`, `in_rs2`, `in_rd` in 5: register indices.
- `in_use_rs1`, `in_use_rs2` in 1: the source is actually read.
- `in_a_pc` in 1: operand A = `in_pc`, otherwise rs1.
- `in_b_imm` in 1: operand B = `in_imm`, otherwise rs2.
- `in_funct` in 4: ALU function code; bit 3 selects sub/arith.
- `alu_a`, `alu_b` out 32: to the ALU operands.
- `alu_funct` out 4: to the ALU function input.
- `alu_o` in 32: ALU combinational result.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: writeback consumes; the register file is written on this handshake.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: result.

## Operation
- **S1 (operand register)** holds: valid, resolved A/B, raw rs1/rs2 values, sources, use flags, select flags, rd, funct.
- **S2 (result register)** holds: valid, rd, data.
- **Handshake logic:**
  - `s1_adv = s1_valid && (!s2_valid || wb_ready)`.
  - `in_ready = !s1_valid || s1_adv`.
  - `wb_valid = s2_valid`.
- **On `s1_adv`:** S2 captures `{in S1 rd, alu_o}`. If S1 does not advance but S2 is consumed, S2 valid clears.
- **Decode contract:** `in_rs*_val` reflects every op whose wb handshake completed before the current cycle.
- **Forwarding (with `ALU_ISSUE_FWD_EN`):**
  - **Entry bypass:** when an op is accepted in the same cycle as a wb handshake with `wb_rd == in_rsX`, `wb_rd != 0` and `in_use_rsX`, S1 captures `wb_data` for that source.
  - **ALU bypass:** when `s2_valid`, `wb_rd == s1_rsX != 0` and the source is used, `alu_a`/`alu_b` use `wb_data` instead of the S1 value.
  - Both bypasses apply only where the operand selects the register, never when the PC or immediate is selected.
  - x0 is never forwarded.
- **Operand drive:** `alu_a`, `alu_b` and `alu_funct` are driven combinationally from S1 plus the ALU bypass. When `!s1_valid` they are driven from S1 contents, which are don't-care.
- **Reset:** S1 and S2 valid = 0; all S1/S2 payload registers = 0. Outputs after reset:
  - `in_ready` = 1, `wb_valid` = 0, `wb_rd` = 0, `wb_data` = 0;
  - `alu_a` = 0, `alu_b` = 0, `alu_funct` = 0.
- **Reset mid-operation** drops all in-flight ops; nothing is replayed.
- **Simultaneous events:** accept into S1, S1→S2 and S2 consume may all occur on one edge. This is full throughput.

## Timing
- An op accepted at edge E is presented to the ALU in the cycle after E. `wb_valid` rises after edge E+1 if S2 was free.
- Latency is 2 cycles; throughput is 1 op/cycle while `wb_ready` = 1.
- When `wb_ready` = 0: S2 holds; S1 holds if full; `in_ready` drops only when both stages are full.
- While stalled, `wb_data` and `wb_rd` are stable.
- A dependent back-to-back op incurs no bubble with forwarding compiled in.

## Configuration
- **`ALU_ISSUE_FWD_EN` defined:** both bypass paths are present and hazards cost zero cycles.
- **`ALU_ISSUE_FWD_EN` undefined:** no bypass muxes; the block interlocks instead.
  - `in_ready` = 0 while any used in-source matches a non-zero rd held in a valid S1 or valid S2 entry. This includes an S2 entry retiring that cycle.
  - Result values are identical to the forwarding build; only timing differs.

## Structure
- Package `alu_pkg`:
  - funct encodings: `ADD`=0, `SUB`=8, `SLL`=1, `SLT`=2, `SLTU`=3, `XOR`=4, `SRL`=5, `SRA`=13, `OR`=6, `AND`=7;
  - typedef for the S1 payload struct;
  - `XLEN` constant.
- Sub-module `fwd_mux`: per-operand compare and select (source index, use flag, reg-select flag, candidate rd/valid/data → operand). Instantiated for the entry bypass and for the ALU bypass of each operand.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid` = 1 → `in_ready` = 1, `wb_valid` = 0, `wb_data` = 0, and no op is accepted during reset.
- **Back-to-back dependency:** ADD x1 = 5 + 7, then SUB x2 = x1 − 2 with stale `in_rs1_val` = 0 → wb gives x1 = 12, then x2 = 10 on consecutive cycles.
- **x0 destination:** ADD x0 = 3 + 4, then ADD x3 = x0 + 1 with `in_rs1_val` = 0 → x3 = 1, no forward.
- **Writeback stall:** hold `wb_ready` = 0 for 3 cycles with 3 ops queued → `wb_data` stable, `in_ready` = 0 once both stages are full, results drain in order at 1/cycle after release.
- **Immediate/PC select:** `in_a_pc` = 1, `in_pc` = 0x100, `in_b_imm` = 1, imm = 0x10, rs1 matching the prior rd → result 0x110, forwarding ignored.
- **Mid-operation reset:** reset with both stages full → `wb_valid` = 0 the next cycle and no stale result appears. Without `ALU_ISSUE_FWD_EN`, rerun the dependency case → one op is held until x1 retires, same values.
